// File: rtl/time_bonus_tally.sv
// time_bonus_tally: latches remaining seconds on level clear and drains them
// into a saturating bonus score, one second per TICKS_PER_STEP clocks.
module time_bonus_tally #(
    parameter int TICKS_PER_STEP    = 250_000,
    parameter int POINTS_PER_SECOND = 50,
    parameter int SECONDS_WIDTH     = 8,
    parameter int SCORE_WIDTH       = 20
) (
    input  logic                     vga_clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SECONDS_WIDTH-1:0] seconds_in,
    input  logic                     timer_done,
    output logic [SECONDS_WIDTH-1:0] seconds_out,
    output logic [SCORE_WIDTH-1:0]   bonus_score,
    output logic                     step,
    output logic                     busy,
    output logic                     done
);
    localparam int TW = $clog2(TICKS_PER_STEP);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;

    state_t                   state, state_next;
    logic [TW-1:0]            tick;
    logic                     tick_last;
    logic [SECONDS_WIDTH-1:0] load_val;
    logic [SCORE_WIDTH:0]     sum;

    assign tick_last = tick == TW'(TICKS_PER_STEP - 1);
    assign load_val  = timer_done ? '0 : seconds_in;
    // one extra bit so the carry out signals saturation
    assign sum       = {1'b0, bonus_score} + (SCORE_WIDTH + 1)'(POINTS_PER_SECOND);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH: state_next = start ? LOAD : state;
            LOAD:         state_next = (load_val == '0) ? FINISH : DRAIN;
            DRAIN:        state_next = (tick_last && seconds_out == SECONDS_WIDTH'(1)) ? FINISH : DRAIN;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            seconds_out <= '0;
            bonus_score <= '0;
            step        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tick        <= '0;
        end else begin
            step <= 1'b0;
            busy <= state_next == LOAD || state_next == DRAIN;
            done <= state_next == FINISH;
            if ((state == IDLE || state == FINISH) && start)
                bonus_score <= '0;
            if (state == LOAD) begin
                seconds_out <= load_val;
                tick        <= '0;
            end
            if (state == DRAIN) begin
                tick <= tick_last ? '0 : tick + TW'(1);
                if (tick_last && seconds_out != '0) begin
                    seconds_out <= seconds_out - SECONDS_WIDTH'(1);
                    bonus_score <= sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
                    step        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_time_bonus_tally.sv
// tb_time_bonus_tally: randomized drains checked against a timeline model
// derived from the step period, points per second and saturation limit.
module tb_time_bonus_tally;
    localparam int TPS = 4;

    logic        vga_clock = 1'b0;
    logic        reset, start, timer_done;
    logic [7:0]  seconds_in, seconds_out, sat_seconds_out, sat_bonus;
    logic [19:0] bonus_score;
    logic        step, busy, done, sat_step, sat_busy, sat_done;
    int          n_tests = 0;
    int          n_fail  = 0;

    time_bonus_tally #(.TICKS_PER_STEP(TPS), .POINTS_PER_SECOND(50), .SECONDS_WIDTH(8), .SCORE_WIDTH(20)) dut (
        .vga_clock(vga_clock), .reset(reset), .start(start), .seconds_in(seconds_in),
        .timer_done(timer_done), .seconds_out(seconds_out), .bonus_score(bonus_score),
        .step(step), .busy(busy), .done(done)
    );

    time_bonus_tally #(.TICKS_PER_STEP(TPS), .POINTS_PER_SECOND(100), .SECONDS_WIDTH(8), .SCORE_WIDTH(8)) dut_sat (
        .vga_clock(vga_clock), .reset(reset), .start(start), .seconds_in(seconds_in),
        .timer_done(timer_done), .seconds_out(sat_seconds_out), .bonus_score(sat_bonus),
        .step(sat_step), .busy(sat_busy), .done(sat_done)
    );

    always #20 vga_clock = ~vga_clock;

    task automatic check(string tag, longint got, longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_seconds"}, seconds_out, 0);
        check({tag, "_bonus"}, bonus_score, 0);
        check({tag, "_step"}, step, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sat_bonus"}, sat_bonus, 0);
        check({tag, "_sat_done"}, sat_done, 0);
    endtask

    // Expected drain timeline: edge 0 samples start, edge 1 latches, step k lands on edge 1+k*TPS
    task automatic drain(int n, bit td, bit noisy);
        int eff  = td ? 0 : n;
        int last = 1 + eff * TPS;
        int k, kr;
        bit step_exp;
        @(negedge vga_clock);
        start = 1'b1;
        seconds_in = 8'(n);
        timer_done = td;
        @(negedge vga_clock);
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_done", done, 0);
        check("load_bonus_clear", bonus_score, 0);
        check("load_sat_clear", sat_bonus, 0);
        check("load_step", step, 0);
        for (int c = 1; c <= last + 3; c++) begin
            start = (noisy && eff > 0 && c <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c > 1) begin
                seconds_in = 8'($urandom_range(0, 255));
                timer_done = 1'($urandom_range(0, 1));
            end
            @(negedge vga_clock);
            kr = (c - 1) / TPS;
            k = kr > eff ? eff : kr;
            step_exp = c > 1 && (c - 1) % TPS == 0 && kr <= eff;
            check("step", step, step_exp);
            check("sat_step", sat_step, step_exp);
            check("seconds_out", seconds_out, eff - k);
            check("sat_seconds_out", sat_seconds_out, eff - k);
            check("bonus_score", bonus_score, k * 50);
            check("sat_bonus", sat_bonus, (k * 100 > 255) ? 255 : k * 100);
            check("busy", busy, c < last);
            check("done", done, c >= last);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        seconds_in = '0;
        timer_done = 1'b0;
        #5 reset = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(negedge vga_clock);
        reset = 1'b0;
        repeat (3) @(negedge vga_clock);
        check_zero("idle");

        drain(3, 0, 0);
        drain(0, 0, 0);
        drain(25, 1, 0);
        drain(3, 0, 1);
        drain(2, 0, 0);
        drain(4, 0, 0);

        @(negedge vga_clock);
        start = 1'b1;
        seconds_in = 8'd5;
        timer_done = 1'b0;
        @(negedge vga_clock);
        start = 1'b0;
        repeat (1 + 2 * TPS) @(negedge vga_clock);
        check("mid_seconds", seconds_out, 3);
        check("mid_bonus", bonus_score, 100);
        #5 reset = 1'b1;
        #1 check_zero("async_reset");
        repeat (2) @(negedge vga_clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge vga_clock);
            check_zero("post_reset");
        end

        for (int i = 0; i < 15; i++)
            drain($urandom_range(0, 6), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
